// File: rtl/isqrt_seq_responder.sv
// isqrt_seq_responder
//   Responder side of the isqrt x/y valid interface. Each accepted radicand
//   is queued in a small FIFO and fed to a sequential restoring square-root
//   engine. The engine produces one result bit per cycle, MSB first, and
//   needs 16 iterations per result. Results come back in request order as
//   one-cycle y_vld pulses. There is no backpressure. A request that arrives
//   while the FIFO is full, and no pop happens in that cycle, is dropped and
//   sets the sticky overflow flag.
//
//   Ports
//     clk       sole clock; all state updates on its rising edge
//     rst       synchronous, active-high reset
//     x_vld     request strobe; x is sampled while high
//     x[31:0]   unsigned radicand
//     y_vld     one-cycle result strobe
//     y[15:0]   floor(sqrt(x)) of the oldest outstanding request; holds
//               its value until the next result
//     overflow  sticky flag; a request was dropped since reset
//
//   Parameter
//     FIFO_DEPTH  request-queue entries; power of two, >= 2
//
//   Build option
//     ISQRT_SEQ_RESPONDER_BYPASS_EN  when defined, a request that arrives
//     while the engine is IDLE and the FIFO is empty loads the engine
//     directly, which saves one cycle of latency.

module isqrt_seq_responder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        y_vld,
  output logic [15:0] y,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [33:0] rem_q, rem_d;
  logic [15:0] root_q, root_d;
  logic [31:0] opnd_q, opnd_d;
  logic [15:0] y_q, y_d;
  logic        yVld_q, yVld_d;
  logic        ovf_q, ovf_d;

  logic [31:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;

  logic        fifoEmpty, fifoFull, pop, push, drop, bypass;
  logic [33:0] remShift, trial, remNext;
  logic [15:0] rootNext;

  // The pointers carry one extra wrap bit. Equal pointers mean the FIFO is
  // empty. Equal indices with different wrap bits mean it is full.
  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

  // Request routing. A pop in the same cycle frees a slot, so a push into
  // a full FIFO still succeeds when the engine drains it in that cycle.
  always_comb begin
    bypass = 1'b0;
`ifdef ISQRT_SEQ_RESPONDER_BYPASS_EN
    bypass = (state_q == IDLE) && fifoEmpty && x_vld;
`endif
    pop  = (state_q == IDLE) && !fifoEmpty;
    push = x_vld && !bypass && (!fifoFull || pop);
    drop = x_vld && !bypass && fifoFull && !pop;
  end

  // One restoring iteration. Bring down the next two radicand bits, then
  // try to subtract 4*root+1. If the subtraction fits, the new result bit
  // is 1 and the remainder is reduced.
  always_comb begin
    remShift = (rem_q << 2) | {32'b0, opnd_q[31:30]};
    trial    = {16'b0, root_q, 2'b01};
    if (remShift >= trial) begin
      remNext  = remShift - trial;
      rootNext = {root_q[14:0], 1'b1};
    end else begin
      remNext  = remShift;
      rootNext = {root_q[14:0], 1'b0};
    end
  end

  // Engine next-state logic. Loading sets the counter to 15. In RUN the
  // counter counts down, and the iteration at count 0 produces the result.
  // The result is registered together with a one-cycle strobe, so the
  // engine is IDLE again in the same cycle that y_vld is high.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    root_d  = root_q;
    opnd_d  = opnd_q;
    y_d     = y_q;
    yVld_d  = 1'b0;
    ovf_d   = ovf_q | drop;
    wrPtr_d = push ? wrPtr_q + PTR_ONE : wrPtr_q;
    rdPtr_d = pop  ? rdPtr_q + PTR_ONE : rdPtr_q;
    case (state_q)
      IDLE: begin
        if (pop || bypass) begin
          opnd_d  = bypass ? x : mem_q[rdPtr_q[AW-1:0]];
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = 4'd15;
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d  = remNext;
        root_d = rootNext;
        opnd_d = opnd_q << 2;
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          yVld_d  = 1'b1;
          y_d     = rootNext;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. Reset discards the in-flight operation and all queued
  // requests, and ignores any request presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      opnd_q  <= '0;
      y_q     <= '0;
      yVld_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      opnd_q  <= opnd_d;
      y_q     <= y_d;
      yVld_q  <= yVld_d;
      ovf_q   <= ovf_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // FIFO storage. It needs no reset because the pointers define which
  // entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wrPtr_q[AW-1:0]] <= x;
    end
  end

  assign y_vld    = yVld_q;
  assign y        = y_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_isqrt_seq_responder.sv
// tb_isqrt_seq_responder
//   Self-checking bench for isqrt_seq_responder. Expected results come from
//   a floor(sqrt) reference computed by binary search on r*r <= x. A queue
//   holds the expected results in request order. Directed sequences cover
//   reset, single requests, bursts, back-to-back issue, overflow, and reset
//   in the middle of a computation. A randomized sweep follows.

module tb_isqrt_seq_responder;

  localparam int FIFO_DEPTH = 4;
`ifdef ISQRT_SEQ_RESPONDER_BYPASS_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 18;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        x_vld = 1'b0;
  logic [31:0] x = '0;
  logic        y_vld;
  logic [15:0] y;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  int vldCount = 0;
  int vldCycles[$];
  int unsigned expQ[$];
  logic [31:0] singles [5] = '{32'd0, 32'd1, 32'd15, 32'd16, 32'hFFFF_FFFF};

  isqrt_seq_responder #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .x_vld    (x_vld),
    .x        (x),
    .y_vld    (y_vld),
    .y        (y),
    .overflow (overflow)
  );

  // Free-running clock and cycle counter used to measure latencies
  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Every comparison in the bench goes through here
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference model: the largest r with r*r <= v
  function automatic int unsigned refSqrt(input logic [31:0] v);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(v)) lo = mid;
      else hi = mid - 1;
    end
    return int'(lo);
  endfunction

  // Presents one request for one cycle. Call this just after a falling edge.
  task automatic applyStimulus(input logic [31:0] v, input bit accept,
                               output int issued);
    x_vld  = 1'b1;
    x      = v;
    issued = cycleCnt;
    if (accept) expQ.push_back(refSqrt(v));
    @(negedge clk);
    x_vld = 1'b0;
  endtask

  // Waits, with a cycle budget, until the result-strobe count reaches target
  task automatic waitPulses(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (vldCount < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (vldCount < target) checkOutput({tag, "Timeout"}, vldCount, target);
  endtask

  // Result monitor: each strobe must match the oldest expected value
  always @(negedge clk) begin
    if (y_vld === 1'b1) begin
      vldCount++;
      vldCycles.push_back(cycleCnt);
      if (expQ.size() == 0) checkOutput("yVldWithNoPending", y_vld, 1'b0);
      else checkOutput("y", {48'b0, y}, {32'b0, expQ.pop_front()});
    end
  end

  initial begin
    int issued;
    int base;
    int n;
    int sent;
    logic [31:0] vals[$];
    logic [31:0] k;

    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("resetYVld", y_vld, 1'b0);
    checkOutput("resetY", y, 16'd0);
    checkOutput("resetOverflow", overflow, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Single requests: latency, exactly one pulse, y holds afterwards
    foreach (singles[i]) begin
      base = vldCount;
      applyStimulus(singles[i], 1'b1, issued);
      waitPulses(base + 1, 40, "single");
      if (vldCount > base) checkOutput("singleLatency", vldCycles[base] - issued, LAT);
      repeat (25) @(negedge clk);
      checkOutput("singlePulseCount", vldCount - base, 1);
      checkOutput("singleYHold", y, refSqrt(singles[i]));
    end

    // Burst of three on consecutive cycles: 17-cycle spacing, no overflow
    base = vldCount;
    applyStimulus(32'd100, 1'b1, issued);
    n = issued;
    applyStimulus(32'd1000000, 1'b1, issued);
    applyStimulus(32'd2, 1'b1, issued);
    waitPulses(base + 3, 100, "burst");
    if (vldCount >= base + 3) begin
      checkOutput("burstLatency", vldCycles[base] - n, LAT);
      checkOutput("burstGap1", vldCycles[base+1] - vldCycles[base], 17);
      checkOutput("burstGap2", vldCycles[base+2] - vldCycles[base+1], 17);
    end
    checkOutput("burstOverflow", overflow, 1'b0);

    // Issue a new request in the same cycle as the previous result
    repeat (3) @(negedge clk);
    base = vldCount;
    applyStimulus(32'd49, 1'b1, issued);
    n = 0;
    while (y_vld !== 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("initiatorFirstVld", y_vld, 1'b1);
    applyStimulus(32'h0001_0000, 1'b1, issued);
    waitPulses(base + 2, 40, "initiator");
    if (vldCount >= base + 2) checkOutput("initiatorLatency", vldCycles[base+1] - issued, LAT);
    checkOutput("initiatorOverflow", overflow, 1'b0);

    // Seven back-to-back requests: FIFO_DEPTH+1 are kept, the rest dropped
    repeat (5) @(negedge clk);
    base = vldCount;
    for (int i = 0; i < 7; i++) applyStimulus($urandom, (i < FIFO_DEPTH + 1), issued);
    waitPulses(base + FIFO_DEPTH + 1, 200, "overflow");
    checkOutput("overflowSet", overflow, 1'b1);
    repeat (40) @(negedge clk);
    checkOutput("overflowPulseCount", vldCount - base, FIFO_DEPTH + 1);
    checkOutput("overflowSticky", overflow, 1'b1);

    // Reset mid-computation with two queued; a request during reset is ignored
    base = vldCount;
    for (int i = 0; i < 3; i++) applyStimulus($urandom, 1'b1, issued);
    repeat (5) @(negedge clk);
    rst   = 1'b1;
    x_vld = 1'b1;
    x     = 32'd12345;
    @(negedge clk);
    rst   = 1'b0;
    x_vld = 1'b0;
    expQ.delete();
    repeat (60) @(negedge clk);
    checkOutput("rstNoVld", vldCount - base, 0);
    checkOutput("rstY", y, 16'd0);
    checkOutput("rstOverflow", overflow, 1'b0);
    base = vldCount;
    applyStimulus(32'd81, 1'b1, issued);
    waitPulses(base + 1, 40, "afterRst");
    if (vldCount > base) checkOutput("afterRstLatency", vldCycles[base] - issued, LAT);
    checkOutput("afterRstY", y, 16'd9);

    // Random sweep plus perfect squares and their predecessors
    vals.push_back(32'hFFFE_0001);
    vals.push_back(32'hFFFE_0000);
    vals.push_back(32'd1);
    vals.push_back(32'd0);
    for (int i = 0; i < 150; i++) begin
      k = 32'($urandom_range(1, 65535));
      vals.push_back(k * k);
      vals.push_back(k * k - 32'd1);
    end
    for (int i = 0; i < 1200; i++) vals.push_back($urandom);
    base = vldCount;
    sent = 0;
    foreach (vals[i]) begin
      n = 0;
      while (expQ.size() >= FIFO_DEPTH && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (expQ.size() >= FIFO_DEPTH) checkOutput("randomStall", expQ.size(), FIFO_DEPTH - 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(vals[i], 1'b1, issued);
      sent++;
    end
    waitPulses(base + sent, 200, "random");
    checkOutput("randomPulseCount", vldCount - base, sent);
    checkOutput("randomOverflow", overflow, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
